fir_output_requant: RTL and testbench

- Downstream stage of the FIR block: consumes the 32-bit signed FIR output each sample and decimates by a fixed ratio.
- Rounds and arithmetic-shifts each kept sample, then saturates it to 16-bit signed.
- Buffers results in a small FIFO behind a valid/ready handshake, so the 16-bit sample stream can feed a DAC or serializer that stalls.

---
 rtl/fir_output_requant.sv | 152 +++++++++++++++
 tb/tb_fir_output_requant.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_requant.sv
// Requantizer behind the FIR: decimate, round and shift, saturate to OUT_W, then buffer in a FWFT FIFO.
// Define FIR_REQUANT_SAT_COUNT_EN to add the sat_count output (saturating count of clipped samples).
module fir_output_requant #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             fifo_full,
    output logic             overflow,
    output logic             sat_flag
`ifdef FIR_REQUANT_SAT_COUNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int R_W  = IN_W + 1;

    localparam logic [PH_W-1:0]        PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [AW:0]            CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic signed [R_W-1:0]  ROUND    = R_W'(1) << (SHIFT - 1);
    localparam logic signed [R_W-1:0]  SAT_HI   = R_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0]  SAT_LO   = ~SAT_HI;

    logic [PH_W-1:0]       phase;
    logic                  keep;
    logic signed [R_W-1:0] in_ext;
    logic signed [R_W-1:0] rounded;
    logic signed [R_W-1:0] s1_data;
    logic                  s1_valid;

    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_W-1:0]      wr_data;

    logic [OUT_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [OUT_W-1:0]      head;
    logic [OUT_W-1:0]      hold_data;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    // One extra bit of headroom so the rounding add cannot wrap near the positive limit.
    assign in_ext  = {in_data[IN_W-1], in_data};
    assign rounded = (in_ext + ROUND) >>> SHIFT;
    assign keep    = in_valid && (phase == '0);

    always_comb begin
        sat_hi  = (s1_data > SAT_HI);
        sat_lo  = (s1_data < SAT_LO);
        wr_data = s1_data[OUT_W-1:0];
        if (sat_hi) begin
            wr_data = SAT_HI[OUT_W-1:0];
        end else if (sat_lo) begin
            wr_data = SAT_LO[OUT_W-1:0];
        end
    end

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign pop       = !empty && out_ready;
    assign push      = s1_valid && (!full || pop);
    assign head      = mem[rd_ptr];
    assign out_valid = !empty;
    assign out_data  = empty ? hold_data : head;
    assign fifo_full = full;

    // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold_data <= '0;
            overflow  <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            phase     <= '0;
            s1_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold_data <= out_data;
            overflow  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
            s1_valid <= keep;
            if (keep) begin
                s1_data <= rounded;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                hold_data <= head;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (s1_valid && full && !pop) begin
                overflow <= 1'b1;
            end
            if (s1_valid && (sat_hi || sat_lo)) begin
                sat_flag <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; count gates visibility, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef FIR_REQUANT_SAT_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (clear) begin
            sat_count <= '0;
        end else if (s1_valid && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_output_requant.sv
// Directed bench for fir_output_requant: one DECIM=1 and one DECIM=4 instance share stimulus.
module tb_fir_output_requant;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        out_valid1, fifo_full1, overflow1, sat_flag1;
    logic [15:0] out_data1;
    logic        out_valid4, fifo_full4, overflow4, sat_flag4;
    logic [15:0] out_data4;
`ifdef FIR_REQUANT_SAT_COUNT_EN
    logic [15:0] sat_count1, sat_count4;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_output_requant #(.DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .fifo_full(fifo_full1), .overflow(overflow1), .sat_flag(sat_flag1)
`ifdef FIR_REQUANT_SAT_COUNT_EN
        , .sat_count(sat_count1)
`endif
    );

    fir_output_requant #(.DECIM(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .fifo_full(fifo_full4), .overflow(overflow4), .sat_flag(sat_flag4)
`ifdef FIR_REQUANT_SAT_COUNT_EN
        , .sat_count(sat_count4)
`endif
    );

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    vec_t vecs[12];
    logic sat_exp;
    int   nsat;
    logic [15:0] drain_exp[4];

    initial begin
        vecs[0]  = '{32'd98304,       16'd3,      1'b0};
        vecs[1]  = '{32'd49152,       16'd2,      1'b0};
        vecs[2]  = '{-32'sd49152,     16'hFFFF,   1'b0};
        vecs[3]  = '{32'd16383,       16'd0,      1'b0};
        vecs[4]  = '{-32'sd16384,     16'd0,      1'b0};
        vecs[5]  = '{-32'sd16385,     16'hFFFF,   1'b0};
        vecs[6]  = '{32'd1073709056,  16'h7FFF,   1'b0};
        vecs[7]  = '{32'd1073725440,  16'h7FFF,   1'b1};
        vecs[8]  = '{32'hC000_0000,   16'h8000,   1'b0};
        vecs[9]  = '{32'hBFFF_BFFF,   16'h8000,   1'b1};
        vecs[10] = '{32'h7FFF_FFFF,   16'h7FFF,   1'b1};
        vecs[11] = '{32'h8000_0000,   16'h8000,   1'b1};

        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held with input activity: nothing may enter.
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            in_data  = 32'h7FFF_FFFF;
            tick();
            check("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
            check("rst_out_data1",  {16'd0, out_data1},  32'd0);
            check("rst_flags1",     {30'd0, overflow1, sat_flag1}, 32'd0);
            check("rst_out_valid4", {31'd0, out_valid4}, 32'd0);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        send(32'd7 << 15);
        tick();
        check("post_rst_keep_valid4", {31'd0, out_valid4}, 32'd1);
        check("post_rst_keep_data4",  {16'd0, out_data4},  32'd7);

        // Rounding / saturation table on DECIM=1, latency exactly two edges.
        do_clear();
        out_ready = 1'b1;
        tick();
        sat_exp = 1'b0;
        nsat    = 0;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].din);
            check($sformatf("lat1_valid[%0d]", i), {31'd0, out_valid1}, 32'd0);
            tick();
            sat_exp = sat_exp | vecs[i].sat;
            if (vecs[i].sat) nsat++;
            check($sformatf("lat2_valid[%0d]", i), {31'd0, out_valid1}, 32'd1);
            check($sformatf("data[%0d]", i),       {16'd0, out_data1},  {16'd0, vecs[i].dout});
            check($sformatf("sat_flag[%0d]", i),   {31'd0, sat_flag1},  {31'd0, sat_exp});
        end
        tick();
        check("empty_after_table", {31'd0, out_valid1}, 32'd0);
        check("hold_after_table",  {16'd0, out_data1},  32'h8000);
`ifdef FIR_REQUANT_SAT_COUNT_EN
        check("sat_count", {16'd0, sat_count1}, nsat);
`endif

        // Decimation by 4 with gaps in in_valid.
        out_ready = 1'b0;
        do_clear();
        for (int k = 1; k <= 8; k++) begin
            send(k << 15);
            if (k == 2 || k == 5) begin
                tick();
                tick();
            end
        end
        tick(); tick(); tick();
        check("decim_valid_a", {31'd0, out_valid4}, 32'd1);
        check("decim_data_a",  {16'd0, out_data4},  32'd1);
        out_ready = 1'b1;
        tick();
        check("decim_valid_b", {31'd0, out_valid4}, 32'd1);
        check("decim_data_b",  {16'd0, out_data4},  32'd5);
        tick();
        check("decim_only_two", {31'd0, out_valid4}, 32'd0);
        out_ready = 1'b0;

        // Backpressure: fill, overflow, simultaneous push/pop while full, ordered drain.
        do_clear();
        for (int k = 1; k <= 6; k++) begin
            in_data  = k << 15;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        check("bp_full",     {31'd0, fifo_full1}, 32'd1);
        check("bp_overflow", {31'd0, overflow1},  32'd1);
        check("bp_head",     {16'd0, out_data1},  32'd1);
        send(32'd7 << 15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_pushpop_full", {31'd0, fifo_full1}, 32'd1);
        drain_exp[0] = 16'd2; drain_exp[1] = 16'd3; drain_exp[2] = 16'd4; drain_exp[3] = 16'd7;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid[%0d]", i), {31'd0, out_valid1}, 32'd1);
            check($sformatf("drain_data[%0d]", i),  {16'd0, out_data1},  {16'd0, drain_exp[i]});
            tick();
        end
        tick();
        check("drain_empty", {31'd0, out_valid1}, 32'd0);
        check("drain_hold",  {16'd0, out_data1},  32'd7);
        out_ready = 1'b0;

        // Mid-stream clear with three entries queued and one in flight.
        do_clear();
        out_ready = 1'b1;
        send(32'd5 << 15);
        tick(); tick();
        out_ready = 1'b0;
        send(32'd1 << 15);
        send(32'h7FFF_FFFF);
        send(32'd2 << 15);
        send(32'd9 << 15);
        check("pre_clr_valid", {31'd0, out_valid1}, 32'd1);
        check("pre_clr_sat",   {31'd0, sat_flag1},  32'd1);
        check("pre_clr_ovf",   {31'd0, overflow1},  32'd0);
        do_clear();
        check("clr_valid",    {31'd0, out_valid1}, 32'd0);
        check("clr_sat",      {31'd0, sat_flag1},  32'd0);
        check("clr_data_kept", {16'd0, out_data1}, 32'd1);
        tick(); tick();
        check("clr_inflight_dropped1", {31'd0, out_valid1}, 32'd0);
        check("clr_inflight_dropped4", {31'd0, out_valid4}, 32'd0);
        send(32'd6 << 15);
        tick();
        check("clr_phase_restart_valid4", {31'd0, out_valid4}, 32'd1);
        check("clr_phase_restart_data4",  {16'd0, out_data4},  32'd6);
`ifdef FIR_REQUANT_SAT_COUNT_EN
        check("clr_sat_count", {16'd0, sat_count1}, 32'd0);
`endif

        // Mid-stream asynchronous reset with three entries queued and one in flight.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(32'd1 << 15);
        send(32'h7FFF_FFFF);
        send(32'd2 << 15);
        send(32'd3 << 15);
        check("pre_rst_valid", {31'd0, out_valid1}, 32'd1);
        check("pre_rst_sat",   {31'd0, sat_flag1},  32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid1", {31'd0, out_valid1}, 32'd0);
        check("arst_data1",  {16'd0, out_data1},  32'd0);
        check("arst_sat1",   {31'd0, sat_flag1},  32'd0);
        check("arst_full1",  {31'd0, fifo_full1}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("arst_inflight1", {31'd0, out_valid1}, 32'd0);
        check("arst_inflight4", {31'd0, out_valid4}, 32'd0);
        send(32'd4 << 15);
        tick();
        check("arst_phase_restart_valid4", {31'd0, out_valid4}, 32'd1);
        check("arst_phase_restart_data4",  {16'd0, out_data4},  32'd4);
        check("arst_data1_after",          {16'd0, out_data1},  32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
